// File: rtl/mux_bus4.sv
// ============================================================================
// Module   : mux_bus4
// Brief    : N-to-1 select of WIDTH-bit slots from a flat bus, with a
//            combinational output and an enable-gated registered copy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_bus4 #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH*NUM_IN-1:0] in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    en,
  output logic [WIDTH-1:0]        out,
  output logic                    sel_err,
  output logic [WIDTH-1:0]        out_q,
  output logic                    out_valid
);

  // One extra bit so NUM_IN == 2**SEL_W is representable in the compare.
  localparam logic [SEL_W:0] C_NUM_IN = (SEL_W + 1)'(NUM_IN);

  generate
    if (NUM_IN > (2 ** SEL_W)) begin : g_param_check
      $error("mux_bus4: NUM_IN exceeds the range of SEL_W");
    end
  endgenerate

  always_comb begin
    out     = '0;
    sel_err = ({1'b0, sel} >= C_NUM_IN);
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        out = in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_q     <= out;
      out_valid <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_bus4.sv
// ============================================================================
// Module   : tb_mux_bus4
// Brief    : Self-checking bench: vector table, hand sequences, random model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_bus4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in;
  logic [2:0]  sel;
  logic        en;
  logic [3:0]  out;
  logic        sel_err;
  logic [3:0]  out_q;
  logic        out_valid;

  logic [23:0] in6;
  logic [2:0]  sel6;
  logic        en6;
  logic [3:0]  out6;
  logic        err6;
  logic [3:0]  outq6;
  logic        valid6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_bus4 dut (
    .clk(clk), .reset(reset), .in(in), .sel(sel), .en(en),
    .out(out), .sel_err(sel_err), .out_q(out_q), .out_valid(out_valid)
  );

  mux_bus4 #(.WIDTH(4), .NUM_IN(6), .SEL_W(3)) dut6 (
    .clk(clk), .reset(reset), .in(in6), .sel(sel6), .en(en6),
    .out(out6), .sel_err(err6), .out_q(outq6), .out_valid(valid6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: slot extraction by shift-and-mask of the flat word.
  function automatic logic [3:0] slot_of(input logic [31:0] word, input int s, input int n);
    if (s >= n) return 4'd0;
    return 4'((word >> (s * 4)) & 32'hF);
  endfunction

  typedef struct {
    logic [31:0] vin;
    logic [2:0]  vsel;
    logic [3:0]  vout;
  } vec_t;

  vec_t vecs[14];

  logic [3:0] m_q;
  logic       m_v;
  logic [3:0] m_q6;
  logic       m_v6;

  initial begin
    vecs[0]  = '{32'hEB2531FC, 3'd3, 4'd3};
    vecs[1]  = '{32'hEB2531FC, 3'd5, 4'd2};
    vecs[2]  = '{32'hEB2531FC, 3'd7, 4'd14};
    vecs[3]  = '{32'hEB2531FC, 3'd0, 4'd12};
    vecs[4]  = '{32'hEB2531FC, 3'd2, 4'd1};
    vecs[5]  = '{32'hEB2531FC, 3'd1, 4'd15};
    vecs[6]  = '{32'hEB2531FC, 3'd4, 4'd5};
    vecs[7]  = '{32'hEB2531FC, 3'd6, 4'd11};
    vecs[8]  = '{32'hE42531FC, 3'd6, 4'd4};
    vecs[9]  = '{32'h76543210, 3'd0, 4'd0};
    vecs[10] = '{32'h76543210, 3'd3, 4'd3};
    vecs[11] = '{32'h76543210, 3'd7, 4'd7};
    vecs[12] = '{32'h0F0F0F0F, 3'd1, 4'd0};
    vecs[13] = '{32'hF0000000, 3'd7, 4'd15};

    reset = 1'b1; en = 1'b0; sel = '0; in = '0;
    in6 = '0; sel6 = '0; en6 = 1'b0;

    // Registered path during reset
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_out_q", 32'(out_q), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
    end

    // Combinational table, no clock involvement
    for (int i = 0; i < 14; i++) begin
      in = vecs[i].vin; sel = vecs[i].vsel;
      #1;
      check($sformatf("comb_out[%0d]", i), 32'(out), 32'(vecs[i].vout));
      check($sformatf("comb_err[%0d]", i), 32'(sel_err), 32'd0);
    end

    // Input change at fixed select, same timestep
    in = 32'hEB2531FC; sel = 3'd6; #1;
    check("fixsel_before", 32'(out), 32'd11);
    in = 32'hE42531FC; #0;
    check("fixsel_after", 32'(out), 32'd4);

    // Registered capture
    @(negedge clk);
    reset = 1'b0; en = 1'b1; sel = 3'd1; in = 32'hEB2531FC;
    @(posedge clk); #1;
    check("cap_out_q", 32'(out_q), 32'd15);
    check("cap_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    en = 1'b0; sel = 3'd4; #1;
    check("hold_out", 32'(out), 32'd5);
    @(posedge clk); #1;
    check("hold_out_q", 32'(out_q), 32'd15);
    check("hold_valid", 32'(out_valid), 32'd1);

    // Reset priority over enable; comb output stays live
    @(negedge clk);
    reset = 1'b1; en = 1'b1; sel = 3'd7; #1;
    check("rstpri_out", 32'(out), 32'd14);
    @(posedge clk); #1;
    check("rstpri_out_q", 32'(out_q), 32'd0);
    check("rstpri_valid", 32'(out_valid), 32'd0);

    // Out-of-range select on the 6-slot build
    @(negedge clk);
    reset = 1'b0; en = 1'b0;
    in6 = 24'h2531FC; sel6 = 3'd1; en6 = 1'b1;
    @(posedge clk); #1;
    check("oor_pre_q", 32'(outq6), 32'd15);
    @(negedge clk);
    sel6 = 3'd6; #1;
    check("oor_out", 32'(out6), 32'd0);
    check("oor_err", 32'(err6), 32'd1);
    @(posedge clk); #1;
    check("oor_out_q", 32'(outq6), 32'd0);
    check("oor_valid", 32'(valid6), 32'd1);
    @(negedge clk);
    sel6 = 3'd5; #1;
    check("inr_err", 32'(err6), 32'd0);
    check("inr_out", 32'(out6), 32'd2);

    // Randomized run against the reference model
    m_q = outq6; m_v = 1'b0; m_q6 = outq6; m_v6 = valid6;
    m_q = out_q; m_v = out_valid;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in    = $urandom;
      sel   = 3'($urandom_range(0, 7));
      en    = 1'($urandom_range(0, 1));
      in6   = 24'($urandom);
      sel6  = 3'($urandom_range(0, 7));
      en6   = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 19) == 0);
      #1;
      check("rnd_out", 32'(out), 32'(slot_of(in, int'(sel), 8)));
      check("rnd_err", 32'(sel_err), 32'd0);
      check("rnd_out6", 32'(out6), 32'(slot_of({8'h0, in6}, int'(sel6), 6)));
      check("rnd_err6", 32'(err6), 32'(int'(sel6) >= 6));
      if (reset) begin
        m_q = 4'd0; m_v = 1'b0; m_q6 = 4'd0; m_v6 = 1'b0;
      end else begin
        if (en)  begin m_q  = slot_of(in, int'(sel), 8);              m_v  = 1'b1; end
        if (en6) begin m_q6 = slot_of({8'h0, in6}, int'(sel6), 6);    m_v6 = 1'b1; end
      end
      @(posedge clk); #1;
      check("rnd_out_q", 32'(out_q), 32'(m_q));
      check("rnd_valid", 32'(out_valid), 32'(m_v));
      check("rnd_out_q6", 32'(outq6), 32'(m_q6));
      check("rnd_valid6", 32'(valid6), 32'(m_v6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
